// File: rtl/sram_wait_responder.sv
// Word-addressed RAM responder that stretches each Mem_OE/Mem_WE access by WAIT_CYCLES
// wait states and reports completion with a one-cycle Ready pulse. Optional SRAM_RESP_WPROT_EN.
module sram_wait_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned WPROT_LIMIT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_to_SRAM,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

`ifdef SRAM_RESP_WPROT_EN
  localparam bit WprotEn = 1'b1;
`else
  localparam bit WprotEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              wprot_hit;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // With protection disabled this folds to 0, so Err is constant low.
  assign wprot_hit = WprotEn && (32'(addr_q) < WPROT_LIMIT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left out of reset; a reset mid-write must not commit.
  always_ff @(posedge Clk) begin
    if (mem_we && !Reset) begin
      mem_q[addr_q] <= data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Mem_WE) begin
          state_d = StWrWait;
        end else if (Mem_OE) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (!Mem_OE) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StHold;
        end
      end
      StWrWait: begin
        if (!Mem_WE) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!Mem_OE && !Mem_WE) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Mem_WE) begin
          addr_d = ADDR;
          data_d = Data_to_SRAM;
          cnt_d  = CntInit;
        end else if (Mem_OE) begin
          addr_d = ADDR;
          cnt_d  = CntInit;
        end
      end
      StRdWait: begin
        if (Mem_OE) begin
          if (cnt_q == 4'd0) begin
            rdata_d = mem_q[addr_q];
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StWrWait: begin
        if (Mem_WE) begin
          if (cnt_q == 4'd0) begin
            ready_d = 1'b1;
            err_d   = wprot_hit;
            mem_we  = !wprot_hit;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StHold: ;
      default: ;
    endcase
  end

  assign Data_from_SRAM = rdata_q;
  assign Ready          = ready_q;
  assign Err            = err_q;
  assign Busy           = (state_q != StIdle);

endmodule

// File: tb/tb_sram_wait_responder.sv
// Directed self-checking bench for sram_wait_responder (default parameters).
module tb_sram_wait_responder;

  logic        Clk;
  logic        Reset;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [7:0]  ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        Ready;
  logic        Busy;
  logic        Err;

  int checks = 0;
  int errors = 0;

  sram_wait_responder dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Mem_OE         (Mem_OE),
    .Mem_WE         (Mem_WE),
    .ADDR           (ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .Ready          (Ready),
    .Busy           (Busy),
    .Err            (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Holds the strobes for `hold` edges (first edge = E0), scrambling ADDR/data after E0,
  // then releases them and samples Busy one edge later. first_* are edge offsets from E0.
  task automatic run_access(input logic we, input logic oe, input logic [7:0] a,
                            input logic [15:0] d, input int hold,
                            output int n_rdy, output int first_rdy, output int n_err,
                            output int first_err, output logic busy_end,
                            output logic busy_after);
    Mem_WE = we;
    Mem_OE = oe;
    ADDR = a;
    Data_to_SRAM = d;
    n_rdy = 0;
    first_rdy = -1;
    n_err = 0;
    first_err = -1;
    busy_end = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge Clk);
      #1;
      if (k == 0) begin
        ADDR = ~a;
        Data_to_SRAM = ~d;
      end
      if (Ready === 1'b1) begin
        n_rdy++;
        if (first_rdy < 0) first_rdy = k;
      end
      if (Err === 1'b1) begin
        n_err++;
        if (first_err < 0) first_err = k;
      end
      busy_end = Busy;
    end
    Mem_WE = 1'b0;
    Mem_OE = 1'b0;
    @(posedge Clk);
    #1;
    busy_after = Busy;
    @(posedge Clk);
    #1;
  endtask

  int   nr, fr, ne, fe;
  logic be, ba;

  task automatic test_reset;
    Reset = 1'b1;
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    ADDR = '0;
    Data_to_SRAM = '0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (Data_from_SRAM !== 16'h0000) begin
      errors++; $display("FAIL reset_data got %h want 0000", Data_from_SRAM);
    end
    checks++;
    if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", Ready); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++;
    if (Err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", Err); end
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_write_read;
    run_access(1'b1, 1'b0, 8'h20, 16'h1234, 5, nr, fr, ne, fe, be, ba);
    checks++;
    if (nr !== 1 || fr !== 2) begin
      errors++; $display("FAIL wr_ready count=%0d edge=%0d want 1 at 2", nr, fr);
    end
    checks++;
    if (be !== 1'b1 || ba !== 1'b0) begin
      errors++; $display("FAIL wr_busy held=%b after=%b want 1 0", be, ba);
    end
    run_access(1'b0, 1'b1, 8'h20, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (nr !== 1 || fr !== 2) begin
      errors++; $display("FAIL rd_ready count=%0d edge=%0d want 1 at 2", nr, fr);
    end
    checks++;
    if (Data_from_SRAM !== 16'h1234) begin
      errors++; $display("FAIL rd_data got %h want 1234", Data_from_SRAM);
    end
  endtask

  task automatic test_abort;
    run_access(1'b1, 1'b0, 8'h21, 16'h5555, 4, nr, fr, ne, fe, be, ba);
    run_access(1'b0, 1'b1, 8'h21, 16'h0000, 1, nr, fr, ne, fe, be, ba);
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL rd_abort_ready count=%0d want 0", nr); end
    checks++;
    if (Data_from_SRAM !== 16'h1234) begin
      errors++; $display("FAIL rd_abort_data got %h want 1234", Data_from_SRAM);
    end
    checks++;
    if (ba !== 1'b0) begin errors++; $display("FAIL rd_abort_idle busy=%b want 0", ba); end
    run_access(1'b1, 1'b0, 8'h21, 16'hAAAA, 1, nr, fr, ne, fe, be, ba);
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL wr_abort_ready count=%0d want 0", nr); end
    run_access(1'b0, 1'b1, 8'h21, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (Data_from_SRAM !== 16'h5555) begin
      errors++; $display("FAIL wr_abort_data got %h want 5555", Data_from_SRAM);
    end
  endtask

  task automatic test_both_strobes;
    run_access(1'b1, 1'b1, 8'h30, 16'hBEEF, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (nr !== 1 || Data_from_SRAM !== 16'h5555) begin
      errors++; $display("FAIL both_write ready=%0d data=%h want 1 5555", nr, Data_from_SRAM);
    end
    run_access(1'b0, 1'b1, 8'h30, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (Data_from_SRAM !== 16'hBEEF) begin
      errors++; $display("FAIL both_read got %h want beef", Data_from_SRAM);
    end
  endtask

  task automatic test_long_hold;
    run_access(1'b0, 1'b1, 8'h20, 16'h0000, 10, nr, fr, ne, fe, be, ba);
    checks++;
    if (nr !== 1) begin errors++; $display("FAIL hold_ready count=%0d want 1", nr); end
    checks++;
    if (be !== 1'b1 || ba !== 1'b0) begin
      errors++; $display("FAIL hold_busy held=%b after=%b want 1 0", be, ba);
    end
    checks++;
    if (Data_from_SRAM !== 16'h1234) begin
      errors++; $display("FAIL hold_data got %h want 1234", Data_from_SRAM);
    end
  endtask

  task automatic test_reset_mid_write;
    run_access(1'b1, 1'b0, 8'h40, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    run_access(1'b0, 1'b1, 8'h20, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    Mem_WE = 1'b1;
    ADDR = 8'h40;
    Data_to_SRAM = 16'h7777;
    @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b want 1", Busy); end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (Data_from_SRAM !== 16'h0000 || Ready !== 1'b0 || Busy !== 1'b0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs data=%h rdy=%b busy=%b err=%b want 0 0 0 0",
               Data_from_SRAM, Ready, Busy, Err);
    end
    Reset = 1'b0;
    Mem_WE = 1'b0;
    @(posedge Clk);
    #1;
    run_access(1'b0, 1'b1, 8'h40, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (Data_from_SRAM !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_array got %h want 0000", Data_from_SRAM);
    end
  endtask

  task automatic test_wprot;
    logic [15:0] prev;
    run_access(1'b0, 1'b1, 8'h05, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    prev = Data_from_SRAM;
    run_access(1'b1, 1'b0, 8'h05, 16'hFFFF, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (nr !== 1 || fr !== 2) begin
      errors++; $display("FAIL wprot_ready count=%0d edge=%0d want 1 at 2", nr, fr);
    end
`ifdef SRAM_RESP_WPROT_EN
    checks++;
    if (ne !== 1 || fe !== 2) begin
      errors++; $display("FAIL wprot_err count=%0d edge=%0d want 1 at 2", ne, fe);
    end
    run_access(1'b0, 1'b1, 8'h05, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (Data_from_SRAM !== prev) begin
      errors++; $display("FAIL wprot_array got %h want %h", Data_from_SRAM, prev);
    end
`else
    checks++;
    if (ne !== 0) begin errors++; $display("FAIL wprot_err count=%0d want 0", ne); end
    run_access(1'b0, 1'b1, 8'h05, 16'h0000, 4, nr, fr, ne, fe, be, ba);
    checks++;
    if (Data_from_SRAM !== 16'hFFFF) begin
      errors++; $display("FAIL wprot_array got %h want ffff (prev %h)", Data_from_SRAM, prev);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_both_strobes();
    test_long_hold();
    test_reset_mid_write();
    test_wprot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
